rocket_frame_gen: RTL

- Animation source for the 8x8 red/green dot-matrix scanner, directly upstream of it.
- Produces the two 64-bit packed frames, col_r_data and col_g_data, that the scanner multiplexes row by row.
- Frames show a rocket on its pad, a blinking-flame countdown, lift-off scrolling upward, a blank gap, then return to the pad.
- Advances only on a one-cycle step_tick enable supplied by the animation-rate divider.

---
 rtl/rocket_pkg.sv | 40 ++++
 rtl/rocket_row_render.sv | 34 +++
 rtl/rocket_frame_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rocket_pkg.sv
// Shared phase encoding, sprite rows and frame helpers for the rocket animation.
package rocket_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    LIFT      = 2'd2,
    GONE      = 2'd3
  } phase_e;

  localparam logic [7:0] NOSE    = 8'h18;
  localparam logic [7:0] BODY    = 8'h3C;
  localparam logic [7:0] FIN     = 8'h7E;
  localparam logic [7:0] FLAME_S = 8'h18;
  localparam logic [7:0] FLAME_L = 8'h3C;
  localparam int         ROWS    = 8;

  // Green sprite row at offset rel below the rocket's top row; blank outside the body.
  function automatic logic [7:0] green_row(int rel);
    logic [7:0] v;
    case (rel)
      0:       v = NOSE;
      1:       v = BODY;
      2:       v = BODY;
      3:       v = FIN;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [63:0] idle_frame(int pad_row);
    logic [63:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++) begin
      f[r*8 +: 8] = green_row(r - pad_row);
    end
    return f;
  endfunction

endpackage

// File: rtl/rocket_row_render.sv
// Combinational renderer for one matrix row: green body and red flame for the current state.
module rocket_row_render
  import rocket_pkg::*;
(
  input  logic [2:0]        row_i,
  input  logic signed [4:0] y_i,
  input  phase_e            phase_i,
  input  logic              fl_i,
  input  logic              cnt0_i,
  output logic [7:0]        red_o,
  output logic [7:0]        green_o
);

  logic signed [5:0] rel;

  assign rel = $signed({3'b000, row_i}) - $signed({y_i[4], y_i});

  // The flame always sits four rows below the nose; in COUNTDOWN y is parked at the pad.
  always_comb begin
    green_o = 8'h00;
    red_o   = 8'h00;
    if (phase_i != GONE) begin
      green_o = green_row(int'(rel));
    end
    if (rel == 6'sd4) begin
      case (phase_i)
        LIFT:      red_o = fl_i ? FLAME_L : FLAME_S;
        COUNTDOWN: red_o = cnt0_i ? 8'h00 : FLAME_S;
        default:   red_o = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/rocket_frame_gen.sv
// Rocket launch animation source: phase FSM plus registered red/green 8x8 frames.
module rocket_frame_gen
  import rocket_pkg::*;
#(
  parameter int COUNT_STEPS = 6,
  parameter int GAP_STEPS   = 4,
  parameter int PAD_ROW     = 3
) (
  input  logic        clk_4000,
  input  logic        rst,
  input  logic        step_tick,
  input  logic        launch,
  output logic [63:0] col_r_data,
  output logic [63:0] col_g_data,
  output logic        busy,
  output logic [1:0]  phase
);

  localparam logic signed [4:0] Y_PAD      = 5'(PAD_ROW);
  localparam logic signed [4:0] Y_END      = -5'sd4;
  localparam logic [3:0]        CNT_LAST   = 4'(COUNT_STEPS - 1);
  localparam logic [3:0]        GAP_LAST   = 4'(GAP_STEPS - 1);
  localparam logic [63:0]       IDLE_FRAME = idle_frame(PAD_ROW);

  phase_e            phase_q, phase_d;
  logic signed [4:0] y_q, y_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              fl_q, fl_d;
  logic [63:0]       col_r_q, col_g_q;
  logic [63:0]       frame_r_d, frame_g_d;

  always_ff @(posedge clk_4000 or negedge rst) begin
    if (!rst) begin
      phase_q <= IDLE;
      y_q     <= Y_PAD;
      cnt_q   <= 4'd0;
      fl_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    fl_d    = fl_q;
    case (phase_q)
      IDLE: begin
        if (launch) begin
          phase_d = COUNTDOWN;
          cnt_d   = 4'd0;
        end
      end
      COUNTDOWN: begin
        if (step_tick) begin
          if (cnt_q == CNT_LAST) begin
            phase_d = LIFT;
            y_d     = Y_PAD;
            fl_d    = 1'b1;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      LIFT: begin
        // The tick seen at y == -4 ends the climb, with only the flame still on row 0.
        if (step_tick) begin
          if (y_q == Y_END) begin
            phase_d = GONE;
            cnt_d   = 4'd0;
          end else begin
            y_d  = y_q - 5'sd1;
            fl_d = ~fl_q;
          end
        end
      end
      GONE: begin
        if (step_tick) begin
          if (cnt_q == GAP_LAST) begin
            phase_d = IDLE;
            y_d     = Y_PAD;
            fl_d    = 1'b0;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: phase_d = IDLE;
    endcase
  end

  for (genvar k = 0; k < ROWS; k++) begin : g_row
    rocket_row_render u_row (
      .row_i   (3'(k)),
      .y_i     (y_q),
      .phase_i (phase_q),
      .fl_i    (fl_q),
      .cnt0_i  (cnt_q[0]),
      .red_o   (frame_r_d[8*k +: 8]),
      .green_o (frame_g_d[8*k +: 8])
    );
  end

  // Whole frames are captured at once so the scanner never sees a half-updated picture.
  always_ff @(posedge clk_4000 or negedge rst) begin
    if (!rst) begin
      col_r_q <= '0;
      col_g_q <= IDLE_FRAME;
    end else begin
      col_r_q <= frame_r_d;
      col_g_q <= frame_g_d;
    end
  end

  assign col_r_data = col_r_q;
  assign col_g_data = col_g_q;
  assign phase      = phase_q;
  assign busy       = (phase_q != IDLE);

endmodule
